// File: rtl/instruction_fetch_pkg.sv
// Shared MIPS IF-stage definitions: special instruction words, FSM encodings
// and the byte-to-word address slicing constant.
package instruction_fetch_pkg;

  localparam logic [31:0] IF_NOP_WORD  = 32'h0000_0000;
  localparam logic [31:0] IF_HALT_WORD = 32'hFFFF_FFFF;

  // PC is a byte address; instruction memory is word addressed.
  localparam int IMEM_WORD_LSB = 2;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } if_state_e;

endpackage

// File: rtl/instruction_fetch_imem.sv
// Word-addressed instruction memory: one synchronous write port used by the
// debug loader and one combinational read port used by fetch. Contents are
// not reset so a program survives a pipeline reset.
module instruction_fetch_imem #(
  parameter int NB_DATA      = 32,
  parameter int NB_IMEM_ADDR = 8
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [NB_IMEM_ADDR-1:0] waddr_i,
  input  logic [NB_DATA-1:0]      wdata_i,
  input  logic [NB_IMEM_ADDR-1:0] raddr_i,
  output logic [NB_DATA-1:0]      rdata_o
);

  localparam int DEPTH = 2 ** NB_IMEM_ADDR;

  logic [NB_DATA-1:0] mem_q [0:DEPTH-1];

  // Write port: store one instruction word per strobed edge.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: program counter, LOAD/RUN/HALT control, instruction memory and
// the IF/ID pipeline register feeding decode.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                 NB_DATA      = 32,
  parameter int                 NB_IMEM_ADDR = 8,
  parameter logic [NB_DATA-1:0] HALT_WORD    = IF_HALT_WORD
) (
  input  logic                    clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_step_en,
  input  logic                    i_stall,
  input  logic                    i_jump,
  input  logic [NB_DATA-1:0]      i_jump_addr,
  input  logic                    i_branch,
  input  logic [NB_DATA-1:0]      i_branch_addr,
  input  logic                    i_imem_we,
  input  logic [NB_IMEM_ADDR-1:0] i_imem_waddr,
  input  logic [NB_DATA-1:0]      i_imem_wdata,
  output logic [NB_DATA-1:0]      o_instruction,
  output logic [NB_DATA-1:0]      o_pcounter4,
  output logic [NB_DATA-1:0]      o_pcounter,
  output logic                    o_halt,
  output logic [1:0]              o_state
);

  localparam logic [NB_DATA-1:0] NOP_WORD = NB_DATA'(IF_NOP_WORD);
  localparam logic [NB_DATA-1:0] ZERO     = {NB_DATA{1'b0}};
  localparam logic [NB_DATA-1:0] PC_INC   = NB_DATA'(4);

  if_state_e          state_q;
  logic [NB_DATA-1:0] pc_q;
  logic [NB_DATA-1:0] instr_q;
  logic [NB_DATA-1:0] pc4_q;
  logic               halt_q;

  logic [NB_DATA-1:0]      fetch_word_s;
  logic [NB_DATA-1:0]      pc_plus4_s;
  logic [NB_DATA-1:0]      redirect_pc_s;
  logic [NB_IMEM_ADDR-1:0] fetch_index_s;
  logic                    adv_s;
  logic                    redirect_s;
  logic                    imem_we_s;

  // Loader writes are only honoured while the pipeline is parked in LOAD.
  assign imem_we_s     = i_imem_we & (state_q == ST_LOAD);
  // Byte PC to word index; low two bits dropped, upper bits wrap the depth.
  assign fetch_index_s = pc_q[NB_IMEM_ADDR+IMEM_WORD_LSB-1:IMEM_WORD_LSB];
  assign pc_plus4_s    = pc_q + PC_INC;
  assign adv_s         = i_step_en & ~i_stall;
  assign redirect_s    = i_jump | i_branch;
  assign redirect_pc_s = i_jump ? i_jump_addr : i_branch_addr;

  instruction_fetch_imem #(
    .NB_DATA      (NB_DATA),
    .NB_IMEM_ADDR (NB_IMEM_ADDR)
  ) u_imem (
    .clk     (clk),
    .we_i    (imem_we_s),
    .waddr_i (i_imem_waddr),
    .wdata_i (i_imem_wdata),
    .raddr_i (fetch_index_s),
    .rdata_o (fetch_word_s)
  );

  // Fetch control: state transitions, PC update and IF/ID register capture.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_LOAD;
      pc_q    <= ZERO;
      instr_q <= NOP_WORD;
      pc4_q   <= ZERO;
      halt_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          pc_q    <= ZERO;
          instr_q <= NOP_WORD;
          pc4_q   <= ZERO;
          halt_q  <= 1'b0;
          if (i_start) begin
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_LOAD;
          end
        end
        ST_RUN: begin
          if (redirect_s) begin
            // Wrong-path slot is flushed; redirect overrides stall/step.
            pc_q    <= redirect_pc_s;
            instr_q <= NOP_WORD;
            pc4_q   <= ZERO;
          end else if (adv_s) begin
            instr_q <= fetch_word_s;
            pc4_q   <= pc_plus4_s;
            if (fetch_word_s == HALT_WORD) begin
              // Halt word drains downstream; PC stays on it.
              state_q <= ST_HALT;
              halt_q  <= 1'b1;
            end else begin
              pc_q <= pc_plus4_s;
            end
          end else begin
            pc_q    <= pc_q;
            instr_q <= instr_q;
            pc4_q   <= pc4_q;
          end
        end
        ST_HALT: begin
          halt_q <= 1'b1;
          if (i_step_en) begin
            instr_q <= NOP_WORD;
            pc4_q   <= ZERO;
          end else begin
            instr_q <= instr_q;
            pc4_q   <= pc4_q;
          end
        end
        default: begin
          state_q <= ST_LOAD;
          pc_q    <= ZERO;
          instr_q <= NOP_WORD;
          pc4_q   <= ZERO;
          halt_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_instruction = instr_q;
  assign o_pcounter4   = pc4_q;
  assign o_pcounter    = pc_q;
  assign o_halt        = halt_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for the IF stage.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic        i_step_en;
  logic        i_stall;
  logic        i_jump;
  logic [31:0] i_jump_addr;
  logic        i_branch;
  logic [31:0] i_branch_addr;
  logic        i_imem_we;
  logic [7:0]  i_imem_waddr;
  logic [31:0] i_imem_wdata;
  logic [31:0] o_instruction;
  logic [31:0] o_pcounter4;
  logic [31:0] o_pcounter;
  logic        o_halt;
  logic [1:0]  o_state;

  int checks   = 0;
  int failures = 0;

  instruction_fetch dut (
    .clk           (clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_step_en     (i_step_en),
    .i_stall       (i_stall),
    .i_jump        (i_jump),
    .i_jump_addr   (i_jump_addr),
    .i_branch      (i_branch),
    .i_branch_addr (i_branch_addr),
    .i_imem_we     (i_imem_we),
    .i_imem_waddr  (i_imem_waddr),
    .i_imem_wdata  (i_imem_wdata),
    .o_instruction (o_instruction),
    .o_pcounter4   (o_pcounter4),
    .o_pcounter    (o_pcounter),
    .o_halt        (o_halt),
    .o_state       (o_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_if(input string tag, input logic [31:0] instr,
                           input logic [31:0] pc4, input logic [31:0] pc);
    check({tag, ".instr"}, o_instruction, instr);
    check({tag, ".pc4"},   o_pcounter4,   pc4);
    check({tag, ".pc"},    o_pcounter,    pc);
  endtask

  task automatic load_word(input logic [7:0] addr, input logic [31:0] data);
    i_imem_we    = 1'b1;
    i_imem_waddr = addr;
    i_imem_wdata = data;
    tick();
    i_imem_we    = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    #2;
    i_rst_n = 1'b0;
    #1;
    expect_if(tag, 32'h0, 32'h0, 32'h0);
    check({tag, ".state"}, {30'd0, o_state}, 32'd0);
    check({tag, ".halt"},  {31'd0, o_halt},  32'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_step_en = 1'b1; i_stall = 1'b0;
    i_jump = 1'b0; i_jump_addr = 32'h0; i_branch = 1'b0; i_branch_addr = 32'h0;
    i_imem_we = 1'b0; i_imem_waddr = 8'h0; i_imem_wdata = 32'h0;
    #2;
    expect_if("reset", 32'h0, 32'h0, 32'h0);
    check("reset.state", {30'd0, o_state}, 32'd0);
    check("reset.halt",  {31'd0, o_halt},  32'd0);
    @(negedge clk);
    i_rst_n = 1'b1;

    // Program plus redirect targets (0x40->16, 0x80->32, 0x10->4, 0xFFFFFFFC->255).
    load_word(8'd0,   32'h2001_0005);
    load_word(8'd1,   32'h2002_0003);
    load_word(8'd2,   32'h0022_1820);
    load_word(8'd3,   32'hFFFF_FFFF);
    load_word(8'd4,   32'h3333_3333);
    load_word(8'd16,  32'h1111_1111);
    load_word(8'd32,  32'h2222_2222);
    load_word(8'd255, 32'h4444_4444);
    check("load.pc", o_pcounter, 32'h0);
    check("load.instr", o_instruction, 32'h0);

    // Run 1: straight-line fetch, stall at PC=8, halt.
    pulse_start();
    check("start.state", {30'd0, o_state}, 32'd1);
    expect_if("start", 32'h0, 32'h0, 32'h0);
    tick(); expect_if("f0", 32'h2001_0005, 32'd4, 32'd4);
    tick(); expect_if("f1", 32'h2002_0003, 32'd8, 32'd8);
    i_stall = 1'b1;
    tick(); expect_if("stall1", 32'h2002_0003, 32'd8, 32'd8);
    tick(); expect_if("stall2", 32'h2002_0003, 32'd8, 32'd8);
    i_stall = 1'b0;
    tick(); expect_if("f2", 32'h0022_1820, 32'd12, 32'd12);
    tick(); expect_if("fhalt", 32'hFFFF_FFFF, 32'd16, 32'd12);
    check("fhalt.halt",  {31'd0, o_halt},  32'd1);
    check("fhalt.state", {30'd0, o_state}, 32'd2);
    i_jump = 1'b1; i_jump_addr = 32'h80;
    tick(); expect_if("halted", 32'h0, 32'h0, 32'd12);
    check("halted.halt", {31'd0, o_halt}, 32'd1);
    i_jump = 1'b0;
    i_start = 1'b1;
    tick(); check("halt.start_ignored", {30'd0, o_state}, 32'd2);
    i_start = 1'b0;
    async_reset("rst_halt");

    // Run 2: memory retained; RUN write ignored; redirects.
    pulse_start();
    i_imem_we = 1'b1; i_imem_waddr = 8'd1; i_imem_wdata = 32'hDEAD_BEEF;
    tick(); expect_if("r2f0", 32'h2001_0005, 32'd4, 32'd4);
    tick(); expect_if("r2f1", 32'h2002_0003, 32'd8, 32'd8);
    i_imem_we = 1'b0;
    i_branch = 1'b1; i_branch_addr = 32'h40;
    tick(); expect_if("branch", 32'h0, 32'h0, 32'h40);
    i_branch = 1'b0;
    tick(); expect_if("br_tgt", 32'h1111_1111, 32'h44, 32'h44);
    i_branch = 1'b1; i_branch_addr = 32'h40; i_jump = 1'b1; i_jump_addr = 32'h80;
    tick(); expect_if("jwins", 32'h0, 32'h0, 32'h80);
    i_branch = 1'b0; i_jump = 1'b0;
    tick(); expect_if("j_tgt", 32'h2222_2222, 32'h84, 32'h84);
    i_stall = 1'b1; i_jump = 1'b1; i_jump_addr = 32'h10;
    tick(); expect_if("jstall", 32'h0, 32'h0, 32'h10);
    i_jump = 1'b0;
    tick(); expect_if("stallhold", 32'h0, 32'h0, 32'h10);
    i_stall = 1'b0; i_step_en = 1'b0;
    tick(); expect_if("stepoff", 32'h0, 32'h0, 32'h10);
    i_step_en = 1'b1;
    tick(); expect_if("step1", 32'h3333_3333, 32'h14, 32'h14);
    i_step_en = 1'b0;
    tick(); expect_if("step0", 32'h3333_3333, 32'h14, 32'h14);
    async_reset("rst_run");

    // Run 3: rerun from 0, then PC wrap at the top of the address space.
    i_step_en = 1'b1;
    pulse_start();
    tick(); expect_if("r3f0", 32'h2001_0005, 32'd4, 32'd4);
    i_jump = 1'b1; i_jump_addr = 32'hFFFF_FFFC;
    tick(); expect_if("jtop", 32'h0, 32'h0, 32'hFFFF_FFFC);
    i_jump = 1'b0;
    tick(); expect_if("wrap", 32'h4444_4444, 32'h0, 32'h0);
    tick(); expect_if("wrapf0", 32'h2001_0005, 32'd4, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
